// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch FSM state type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode hand-off signals of the fetch stage.
interface fetch_unit_if #(parameter int XLEN = riscv_pkg::XLEN);
    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [XLEN-1:0]            imem_req_addr;
    logic                       imem_rsp_valid;
    logic [riscv_pkg::ILEN-1:0] imem_rsp_data;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_target;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [riscv_pkg::ILEN-1:0] instr;
    logic [XLEN-1:0]            instr_pc;
    logic                       misaligned;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misaligned,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misaligned,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush; accepts a push while full if the head pops that cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited in-order imem requests, stale-response discard and decode FIFO.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ILEN + XLEN;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding, out_next, fifo_count;
    logic [EW-1:0]   head;
    logic            hs, rsp, redirect, push, fifo_full, fifo_empty, misaligned_q;

    assign redirect = bus.redirect_valid && state != BOOT;
    assign hs       = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp      = bus.imem_rsp_valid;
    assign out_next = outstanding + CW'(hs) - CW'(rsp);
    // In FLUSH every in-flight request is stale, so outstanding doubles as the discard count.
    assign push     = rsp && state == RUN && !redirect;

    assign bus.imem_req_valid = state == RUN && !fifo_full && int'(outstanding) + int'(fifo_count) < DEPTH;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = !fifo_empty;
    assign {bus.instr, bus.instr_pc} = head;
    assign bus.misaligned     = misaligned_q;

    // Responses return in order, so the oldest in-flight request sits outstanding words behind pc.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.instr_valid && bus.instr_ready),
        .flush (redirect),
        .din   ({bus.imem_rsp_data, pc - (XLEN'(outstanding) << 2)}),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            outstanding  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            outstanding  <= out_next;
            misaligned_q <= redirect && bus.redirect_target[1:0] != 2'b00;
            if (redirect) begin
                pc    <= {bus.redirect_target[XLEN-1:2], 2'b00};
                state <= out_next == '0 ? RUN : FLUSH;
            end else begin
                if (hs) pc <= pc + XLEN'(4);
                if (state == BOOT || (state == FLUSH && out_next == '0)) state <= RUN;
            end
        end
    end
endmodule
